min_hour_day_chain: RTL and testbench

//  Cascaded time-of-week counter: minute (0-59), hour (0-HOUR_MOD-1), day-of-week (0-DAY_MOD-1).

---
 rtl/min_hour_day_chain_if.sv | 26 ++
 rtl/min_hour_day_chain.sv | 89 ++++++++
 tb/tb_min_hour_day_chain.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/min_hour_day_chain_if.sv
// Control and read-back bundle for the minute/hour/day-of-week stage.
// The master side (seconds stage / host) drives strobes and bus data; the slave side reports counts and carries.
interface min_hour_day_chain_if;
    logic       load;
    logic [1:0] load_sel;
    logic       enable;
    logic [5:0] data_in;
    logic       sec_carry;
    logic [5:0] minute;
    logic [4:0] hour;
    logic [2:0] day;
    logic [5:0] data_out;
    logic       min_carry;
    logic       hour_carry;
    logic       day_carry;

    modport master (
        output load, load_sel, enable, data_in, sec_carry,
        input  minute, hour, day, data_out, min_carry, hour_carry, day_carry
    );

    modport slave (
        input  load, load_sel, enable, data_in, sec_carry,
        output minute, hour, day, data_out, min_carry, hour_carry, day_carry
    );
endinterface

// File: rtl/min_hour_day_chain.sv
// Cascaded minute / hour / day-of-week counter driven by the seconds-stage carry.
// Supports per-field preset from the shared data bus and combinational read-back of one field.
module min_hour_day_chain #(
    parameter int MIN_MOD  = 60,
    parameter int HOUR_MOD = 24,
    parameter int DAY_MOD  = 7
) (
    input logic            clk,
    input logic            clear,
    min_hour_day_chain_if.slave bus
);

    typedef enum logic [1:0] {
        SEL_MIN  = 2'd0,
        SEL_HOUR = 2'd1,
        SEL_DAY  = 2'd2,
        SEL_NONE = 2'd3
    } field_sel_e;

    localparam logic [5:0] MIN_LAST   = 6'(MIN_MOD - 1);
    localparam logic [4:0] HOUR_LAST  = 5'(HOUR_MOD - 1);
    localparam logic [2:0] DAY_LAST   = 3'(DAY_MOD - 1);
    // Limits are one bit wider than the field so a full power-of-two modulus still compares correctly.
    localparam logic [6:0] MIN_LIMIT  = 7'(MIN_MOD);
    localparam logic [5:0] HOUR_LIMIT = 6'(HOUR_MOD);
    localparam logic [3:0] DAY_LIMIT  = 4'(DAY_MOD);

    logic [5:0] minute_q;
    logic [4:0] hour_q;
    logic [2:0] day_q;
    logic       min_carry;
    logic       hour_carry;
    logic       day_carry;
    logic       min_load_ok;
    logic       hour_load_ok;
    logic       day_load_ok;

    assign min_carry  = clear & bus.enable & ~bus.load & bus.sec_carry & (minute_q == MIN_LAST);
    assign hour_carry = min_carry & (hour_q == HOUR_LAST);
    assign day_carry  = hour_carry & (day_q == DAY_LAST);

    assign min_load_ok  = ({1'b0, bus.data_in}      < MIN_LIMIT);
    assign hour_load_ok = ({1'b0, bus.data_in[4:0]} < HOUR_LIMIT);
    assign day_load_ok  = ({1'b0, bus.data_in[2:0]} < DAY_LIMIT);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            minute_q <= '0;
            hour_q   <= '0;
            day_q    <= '0;
        end else if (bus.load) begin
            // Out-of-range presets are dropped so a field never holds a value at or above its modulus.
            case (field_sel_e'(bus.load_sel))
                SEL_MIN:  if (min_load_ok)  minute_q <= bus.data_in;
                SEL_HOUR: if (hour_load_ok) hour_q   <= bus.data_in[4:0];
                SEL_DAY:  if (day_load_ok)  day_q    <= bus.data_in[2:0];
                default:  ;
            endcase
        end else if (bus.enable) begin
            if (bus.sec_carry) begin
                minute_q <= (minute_q == MIN_LAST) ? 6'd0 : minute_q + 6'd1;
            end
            if (min_carry) begin
                hour_q <= (hour_q == HOUR_LAST) ? 5'd0 : hour_q + 5'd1;
            end
            if (hour_carry) begin
                day_q <= (day_q == DAY_LAST) ? 3'd0 : day_q + 3'd1;
            end
        end
    end

    always_comb begin
        bus.data_out = 6'd0;
        case (field_sel_e'(bus.load_sel))
            SEL_MIN:  bus.data_out = minute_q;
            SEL_HOUR: bus.data_out = {1'b0, hour_q};
            SEL_DAY:  bus.data_out = {3'b000, day_q};
            default:  bus.data_out = 6'd0;
        endcase
    end

    assign bus.minute     = minute_q;
    assign bus.hour       = hour_q;
    assign bus.day        = day_q;
    assign bus.min_carry  = min_carry;
    assign bus.hour_carry = hour_carry;
    assign bus.day_carry  = day_carry;

endmodule

// File: tb/tb_min_hour_day_chain.sv
// Directed bench for min_hour_day_chain: one task per scenario with hand-computed expectations.
module tb_min_hour_day_chain;

    logic clk;
    logic clear;
    int   compared;
    int   mismatched;

    min_hour_day_chain_if bus_if ();

    min_hour_day_chain #(
        .MIN_MOD  (60),
        .HOUR_MOD (24),
        .DAY_MOD  (7)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [1:0] sel, input logic [5:0] value);
        bus_if.load      = 1'b1;
        bus_if.load_sel  = sel;
        bus_if.data_in   = value;
        tick();
        bus_if.load      = 1'b0;
        bus_if.load_sel  = 2'd3;
        bus_if.data_in   = 6'd0;
    endtask

    task automatic test_reset();
        clear            = 1'b0;
        bus_if.load      = 1'b0;
        bus_if.load_sel  = 2'd0;
        bus_if.enable    = 1'b1;
        bus_if.data_in   = 6'd0;
        bus_if.sec_carry = 1'b1;
        #1;
        compared++;
        if (bus_if.minute !== 6'd0 || bus_if.hour !== 5'd0 || bus_if.day !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_fields: got %0d/%0d/%0d want 0/0/0", bus_if.minute, bus_if.hour, bus_if.day);
        end
        tick();
        tick();
        compared++;
        if (bus_if.minute !== 6'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_hold_minute: got %0d want 0", bus_if.minute);
        end
        compared++;
        if ({bus_if.min_carry, bus_if.hour_carry, bus_if.day_carry} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_carries: got %b want 000", {bus_if.min_carry, bus_if.hour_carry, bus_if.day_carry});
        end
        compared++;
        if (bus_if.data_out !== 6'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_data_out: got %0d want 0", bus_if.data_out);
        end
        bus_if.sec_carry = 1'b0;
        bus_if.load_sel  = 2'd3;
        #2 clear = 1'b1;
        tick();
    endtask

    task automatic test_async_clear();
        preset(2'd0, 6'd17);
        preset(2'd1, 6'd5);
        compared++;
        if (bus_if.minute !== 6'd17 || bus_if.hour !== 5'd5) begin
            mismatched++;
            $display("[TB] FAIL clear_preset: got %0d/%0d want 17/5", bus_if.minute, bus_if.hour);
        end
        #2 clear = 1'b0;
        #1;
        compared++;
        if (bus_if.minute !== 6'd0 || bus_if.hour !== 5'd0 || bus_if.day !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL clear_async: got %0d/%0d/%0d want 0/0/0", bus_if.minute, bus_if.hour, bus_if.day);
        end
        tick();
        #2 clear = 1'b1;
        tick();
        bus_if.enable    = 1'b1;
        bus_if.sec_carry = 1'b1;
        tick();
        bus_if.sec_carry = 1'b0;
        compared++;
        if (bus_if.minute !== 6'd1) begin
            mismatched++;
            $display("[TB] FAIL clear_resume: got %0d want 1", bus_if.minute);
        end
    endtask

    task automatic test_minute_wrap();
        preset(2'd0, 6'd58);
        preset(2'd1, 6'd0);
        bus_if.enable    = 1'b1;
        bus_if.sec_carry = 1'b1;
        #1;
        compared++;
        if (bus_if.min_carry !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wrap_carry_first: got %b want 0", bus_if.min_carry);
        end
        tick();
        compared++;
        if (bus_if.minute !== 6'd59) begin
            mismatched++;
            $display("[TB] FAIL wrap_minute_59: got %0d want 59", bus_if.minute);
        end
        compared++;
        if (bus_if.min_carry !== 1'b1 || bus_if.hour_carry !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wrap_carry_second: got %b%b want 10", bus_if.min_carry, bus_if.hour_carry);
        end
        tick();
        bus_if.sec_carry = 1'b0;
        #1;
        compared++;
        if (bus_if.minute !== 6'd0 || bus_if.hour !== 5'd1) begin
            mismatched++;
            $display("[TB] FAIL wrap_rollover: got %0d/%0d want 0/1", bus_if.minute, bus_if.hour);
        end
        compared++;
        if (bus_if.min_carry !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wrap_carry_after: got %b want 0", bus_if.min_carry);
        end
    endtask

    task automatic test_full_wrap();
        preset(2'd0, 6'd59);
        preset(2'd1, 6'd23);
        preset(2'd2, 6'd6);
        bus_if.enable    = 1'b1;
        bus_if.sec_carry = 1'b1;
        #1;
        compared++;
        if ({bus_if.min_carry, bus_if.hour_carry, bus_if.day_carry} !== 3'b111) begin
            mismatched++;
            $display("[TB] FAIL full_carries: got %b want 111", {bus_if.min_carry, bus_if.hour_carry, bus_if.day_carry});
        end
        tick();
        bus_if.sec_carry = 1'b0;
        #1;
        compared++;
        if (bus_if.minute !== 6'd0 || bus_if.hour !== 5'd0 || bus_if.day !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL full_rollover: got %0d/%0d/%0d want 0/0/0", bus_if.minute, bus_if.hour, bus_if.day);
        end
        preset(2'd1, 6'd22);
        bus_if.sec_carry = 1'b1;
        preset(2'd0, 6'd59);
        #1;
        compared++;
        if ({bus_if.min_carry, bus_if.hour_carry, bus_if.day_carry} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL partial_carries: got %b want 100", {bus_if.min_carry, bus_if.hour_carry, bus_if.day_carry});
        end
        tick();
        bus_if.sec_carry = 1'b0;
        compared++;
        if (bus_if.hour !== 5'd23 || bus_if.day !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL partial_hour: got %0d/%0d want 23/0", bus_if.hour, bus_if.day);
        end
    endtask

    task automatic test_load_range();
        preset(2'd1, 6'd0);
        preset(2'd1, 6'd24);
        compared++;
        if (bus_if.hour !== 5'd0) begin
            mismatched++;
            $display("[TB] FAIL load_hour_oob: got %0d want 0", bus_if.hour);
        end
        preset(2'd1, 6'd13);
        bus_if.load_sel = 2'd1;
        #1;
        compared++;
        if (bus_if.hour !== 5'd13 || bus_if.data_out !== 6'd13) begin
            mismatched++;
            $display("[TB] FAIL load_hour_13: got %0d/%0d want 13/13", bus_if.hour, bus_if.data_out);
        end
        preset(2'd0, 6'd60);
        compared++;
        if (bus_if.minute !== 6'd0) begin
            mismatched++;
            $display("[TB] FAIL load_minute_oob: got %0d want 0", bus_if.minute);
        end
        preset(2'd2, 6'd5);
        preset(2'd2, 6'd7);
        bus_if.load_sel = 2'd2;
        #1;
        compared++;
        if (bus_if.day !== 3'd5 || bus_if.data_out !== 6'd5) begin
            mismatched++;
            $display("[TB] FAIL load_day: got %0d/%0d want 5/5", bus_if.day, bus_if.data_out);
        end
        preset(2'd0, 6'd42);
        bus_if.load_sel = 2'd0;
        #1;
        compared++;
        if (bus_if.data_out !== 6'd42) begin
            mismatched++;
            $display("[TB] FAIL readback_minute: got %0d want 42", bus_if.data_out);
        end
        bus_if.load_sel = 2'd3;
        #1;
        compared++;
        if (bus_if.data_out !== 6'd0) begin
            mismatched++;
            $display("[TB] FAIL readback_none: got %0d want 0", bus_if.data_out);
        end
    endtask

    task automatic test_enable();
        preset(2'd0, 6'd59);
        preset(2'd1, 6'd4);
        bus_if.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_if.sec_carry = 1'b1;
            #1;
            compared++;
            if (bus_if.min_carry !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL disabled_carry: pulse %0d got %b want 0", i, bus_if.min_carry);
            end
            tick();
            bus_if.sec_carry = 1'b0;
            tick();
        end
        compared++;
        if (bus_if.minute !== 6'd59 || bus_if.hour !== 5'd4) begin
            mismatched++;
            $display("[TB] FAIL disabled_hold: got %0d/%0d want 59/4", bus_if.minute, bus_if.hour);
        end
        bus_if.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_if.sec_carry = 1'b1;
            tick();
            bus_if.sec_carry = 1'b0;
            tick();
        end
        compared++;
        if (bus_if.minute !== 6'd2 || bus_if.hour !== 5'd5) begin
            mismatched++;
            $display("[TB] FAIL enabled_count: got %0d/%0d want 2/5", bus_if.minute, bus_if.hour);
        end
    endtask

    task automatic test_load_priority();
        preset(2'd0, 6'd59);
        preset(2'd1, 6'd13);
        bus_if.enable    = 1'b1;
        bus_if.sec_carry = 1'b1;
        bus_if.load      = 1'b1;
        bus_if.load_sel  = 2'd1;
        bus_if.data_in   = 6'd7;
        #1;
        compared++;
        if (bus_if.min_carry !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL load_blocks_carry: got %b want 0", bus_if.min_carry);
        end
        tick();
        compared++;
        if (bus_if.minute !== 6'd59 || bus_if.hour !== 5'd7) begin
            mismatched++;
            $display("[TB] FAIL load_priority: got %0d/%0d want 59/7", bus_if.minute, bus_if.hour);
        end
        bus_if.load_sel = 2'd3;
        bus_if.data_in  = 6'd3;
        tick();
        compared++;
        if (bus_if.minute !== 6'd59 || bus_if.hour !== 5'd7 || bus_if.day !== 3'd5) begin
            mismatched++;
            $display("[TB] FAIL load_freeze: got %0d/%0d/%0d want 59/7/5", bus_if.minute, bus_if.hour, bus_if.day);
        end
        bus_if.load = 1'b0;
        tick();
        bus_if.sec_carry = 1'b0;
        compared++;
        if (bus_if.minute !== 6'd0 || bus_if.hour !== 5'd8) begin
            mismatched++;
            $display("[TB] FAIL after_load_count: got %0d/%0d want 0/8", bus_if.minute, bus_if.hour);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_async_clear();
        test_minute_wrap();
        test_full_wrap();
        test_load_range();
        test_enable();
        test_load_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
